// File: rtl/sum_accumulator_pkg.sv
// Shared types and the saturating-add helper for the sum accumulator.
// sat_add works on a fixed 64-bit carrier; sat_adder slices it to the real width.
package sum_accumulator_pkg;

  typedef enum logic {ACC_ST_ACCUM, ACC_ST_HOLD} acc_state_e;

  localparam int unsigned SAT_CARRIER_W = 64;

  // Returns {carry, clamped}; clamped saturates at 2^width-1 (width <= 63).
  function automatic logic [SAT_CARRIER_W:0] sat_add(
    input logic [SAT_CARRIER_W-1:0] acc,
    input logic [SAT_CARRIER_W-1:0] inc,
    input int unsigned              width
  );
    logic [SAT_CARRIER_W:0]   full;
    logic [SAT_CARRIER_W-1:0] max_val;
    logic                     carry;
    max_val = {SAT_CARRIER_W{1'b1}} >> (SAT_CARRIER_W - width);
    full    = {1'b0, acc} + {1'b0, inc};
    carry   = (full > {1'b0, max_val});
    return {carry, (carry ? max_val : full[SAT_CARRIER_W-1:0])};
  endfunction

endpackage

// File: rtl/sum_accumulator_sat_adder.sv
// Combinational W-bit saturating adder; carry flags that the result was clamped.
module sat_adder
  import sum_accumulator_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [SAT_CARRIER_W:0] result;
  logic                   unused_hi;

  assign result    = sat_add(SAT_CARRIER_W'(a), SAT_CARRIER_W'(b), W);
  assign sum       = result[W-1:0];
  assign carry     = result[SAT_CARRIER_W];
  assign unused_hi = ^result[SAT_CARRIER_W-1:W];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates frames of adder sums into a saturating total with beat count and
// sticky overflow. Handshakes: a transfer happens on any cycle where valid && ready.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int COUNT      = 4,
  parameter int CNT_W      = $clog2(COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_sum,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_overflow
);

  if (ACC_WIDTH < DATA_WIDTH + 1) begin : g_bad_acc_width
    $error("sum_accumulator: ACC_WIDTH must be >= DATA_WIDTH+1");
  end
  if (ACC_WIDTH > 63) begin : g_bad_acc_max
    $error("sum_accumulator: ACC_WIDTH must be <= 63");
  end
  if (COUNT < 1) begin : g_bad_count
    $error("sum_accumulator: COUNT must be >= 1");
  end

  acc_state_e           state, state_next;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf;

  logic                 accept;
  logic                 close_frame;
  logic                 release_frame;
  logic [CNT_W-1:0]     cnt_inc;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 acc_carry;

  sat_adder #(.W(ACC_WIDTH)) u_sat_adder (
    .a     (acc),
    .b     (ACC_WIDTH'(in_sum)),
    .sum   (acc_sum),
    .carry (acc_carry)
  );

  assign cnt_inc = cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACC_ST_ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    accept        = 1'b0;
    close_frame   = 1'b0;
    release_frame = 1'b0;
    case (state)
      ACC_ST_ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        // A lone flush on an empty frame is dropped rather than emitting a zero-beat result.
        close_frame = (accept && (cnt_inc == CNT_W'(COUNT)))
                   || (flush && ((cnt != '0) || accept));
        if (close_frame) state_next = ACC_ST_HOLD;
      end
      ACC_ST_HOLD: begin
        out_valid     = 1'b1;
        release_frame = out_ready;
        if (out_ready) state_next = ACC_ST_ACCUM;
      end
      default: state_next = ACC_ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (release_frame) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt_inc;
      ovf <= ovf | acc_carry;
    end
  end

  assign out_data     = acc;
  assign out_count    = cnt;
  assign out_overflow = ovf;

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream stage for the combinational `adder`: consumes its unsigned `DATA_WIDTH+1`-bit sum `X` over a valid/ready handshake. It accumulates a frame of `COUNT` sums, or fewer when flushed, into a saturating `ACC_WIDTH`-bit total. It then presents the total, beat count and a sticky overflow flag on an output handshake. This is the first clocked stage after the adder and turns per-operand sums into frame totals for the rest of the datapath.

## Interface
- `DATA_WIDTH`, default 8: adder operand width; input sum is `DATA_WIDTH+1` bits.
- `ACC_WIDTH`, default 16: accumulator/output width; must be ≥ `DATA_WIDTH+1` (elaboration error otherwise).
- `COUNT`, default 4: beats per frame; must be ≥ 1. `CNT_W = $clog2(COUNT+1)`.
- `clk` in, 1: the single clock; all state on rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `in_valid` in, 1: `in_sum` is valid.
- `in_ready` out, 1: block accepts a beat this cycle.
- `in_sum` in, `DATA_WIDTH+1`: unsigned sum from the adder (`X`).
- `flush` in, 1: single-cycle request to close the current frame early.
- `out_valid` out, 1: frame result is valid.
- `out_ready` in, 1: consumer accepts the result.
- `out_data` out, `ACC_WIDTH`: frame total (saturated).
- `out_count` out, `CNT_W`: beats in this frame (1..`COUNT`).
- `out_overflow` out, 1: saturation occurred at any beat of this frame.

## Operation
- FSM states:
  - `ACCUM`: `in_ready=1`, `out_valid=0`.
  - `HOLD`: `in_ready=0`, `out_valid=1`.
- Accept: `in_valid && in_ready`.
  - `acc <= sat(acc + zero_ext(in_sum))`, where `sat` clamps to `2^ACC_WIDTH-1`.
  - `cnt <= cnt+1`.
  - `ovf <= ovf | carry`.
- `ACCUM` -> `HOLD` when either:
  - an accept makes `cnt` reach `COUNT`, or
  - `flush` is high with (`cnt>0` or an accept this cycle).
- Flush and accept in the same cycle: the beat is included and the frame closes.
- `flush` with `cnt==0` and no accept: ignored.
- `flush` in `HOLD`: ignored; it is not queued.
- `HOLD` -> `ACCUM` on `out_ready`. That edge clears `acc`, `cnt` and `ovf`.
- `out_data`, `out_count` and `out_overflow` are driven from the registers. They stay stable while `out_valid && !out_ready`.
- No accept can occur in `HOLD`. Upstream must hold `in_valid`/`in_sum` until `in_ready`.
- Reset values:
  - state `ACCUM`; `acc=0`, `cnt=0`, `ovf=0`.
  - outputs: `in_ready=1`, `out_valid=0`, `out_data=0`, `out_count=0`, `out_overflow=0`.
- Reset mid-frame or mid-`HOLD`: the partial frame or pending result is discarded; no output is produced for it.

## Timing
- Accumulate latency: an accepted beat is visible in `acc` on the next edge.
- Result latency: `out_valid` rises the cycle after the closing accept or flush.
- Handshake bubble:
  - The output handshake cycle has `in_ready=0`.
  - `in_ready` returns to 1 the cycle after `out_ready` is sampled high.
- Minimum frame period is `COUNT+1` cycles.
- `COUNT=1`: every accept goes straight to `HOLD`.
- Saturation is per beat. Once at max, `acc` stays at `2^ACC_WIDTH-1` for the rest of the frame.

## Structure
- Package `sum_accumulator_pkg`:
  - `typedef enum logic {ACC_ST_ACCUM, ACC_ST_HOLD} acc_state_e`.
  - Function `sat_add(acc, inc)` returning `{carry, clamped}`, width via `ACC_WIDTH` parameterised wrapper.
- One sub-module: `sat_adder`, a combinational `ACC_WIDTH`-bit saturating adder with carry/overflow output, instantiated once.
- FSM, counter and output registers stay in `sum_accumulator`.

## Test plan
All scenarios use `DATA_WIDTH=8`, `ACC_WIDTH=10`, `COUNT=4`.
- Back-to-back sums 100, 200, 300, 400 with `out_ready=1` -> one result: `out_data=1000`, `out_count=4`, `out_overflow=0`. `in_ready` is low for exactly 1 cycle.
- Four beats of 511 -> `out_data=1023`, `out_overflow=1`. The next frame of 1, 1, 1, 1 -> `out_data=4`, `out_overflow=0`.
- Full frame, then `out_ready=0` for 5 cycles while `in_valid=1` with 7 -> `in_ready=0` and outputs stable throughout. After `out_ready`, 7 is accepted as beat 1 of the next frame.
- Beats 10, 20, then `flush` alone -> `out_data=30`, `out_count=2`. Then `flush` with `cnt==0` -> no result.
- Beats 5, 6, then beat 7 with `flush` in the same cycle -> `out_data=18`, `out_count=3`. A `flush` during `HOLD` produces no extra frame.
- Beats 50, 60, then `rst` pulsed asynchronously mid-cycle -> outputs return to reset values immediately. The next frame 1, 2, 3, 4 -> `out_data=10`.
